// File: rtl/ysyx_24080006_icache.sv
// Direct-mapped, read-only instruction cache between the IFU AXI read port (s_*) and the system bus (m_*).
// Misses refill a whole line with one INCR burst; fence_i invalidates every line at the next idle cycle.
module ysyx_24080006_icache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fence_i,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [3:0]  s_rid,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast
);
    localparam int unsigned OFFW = $clog2(WORDS);
    localparam int unsigned IDXW = $clog2(LINES);
    localparam int unsigned LSB  = OFFW + 2;
    localparam int unsigned TAGW = 32 - LSB - IDXW;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, RESP} state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             fence_pend_q, fence_pend_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             err_q, err_d;
    logic             m_arvalid_q, m_arvalid_d;
    logic [OFFW:0]    cnt_q, cnt_d;

    logic [31:0]      data_q [LINES*WORDS];
    logic [TAGW-1:0]  tag_q  [LINES];

    logic [OFFW-1:0]      off;
    logic [IDXW-1:0]      idx;
    logic [TAGW-1:0]      tag;
    logic                 hit;
    logic                 beat;
    logic                 cnt_ovf;
    logic                 cnt_at_last;
    logic                 beat_bad;
    logic [1:0]           beat_code;
    logic                 fence_apply;
    logic                 data_we;
    logic                 tag_we;
    logic [IDXW+OFFW-1:0] data_waddr;
    logic                 unused_inputs;

    assign off = addr_q[LSB-1:2];
    assign idx = addr_q[LSB+IDXW-1:LSB];
    assign tag = addr_q[31:LSB+IDXW];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    // cnt saturates at WORDS, so its MSB flags a beat past the end of the line
    assign beat        = (state_q == REFILL) && m_rvalid;
    assign cnt_ovf     = cnt_q[OFFW];
    assign cnt_at_last = !cnt_ovf && (&cnt_q[OFFW-1:0]);
    assign beat_bad    = cnt_ovf || (m_rlast && !cnt_at_last);
    assign beat_code   = (m_rresp != 2'b00) ? m_rresp : (beat_bad ? 2'b10 : 2'b00);
    assign fence_apply = (state_q == IDLE) && fence_pend_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (s_arvalid && !fence_pend_q) state_d = LOOKUP;
            LOOKUP:  state_d = hit ? RESP : MISS_AR;
            MISS_AR: if (m_arready) state_d = REFILL;
            REFILL:  if (beat && m_rlast) state_d = RESP;
            RESP:    if (s_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        s_arready = (state_q == IDLE) && !fence_pend_q && !reset;
        s_rvalid  = (state_q == RESP);
        m_rready  = (state_q == REFILL);
    end

    // Datapath next values and array write controls
    always_comb begin
        addr_d       = addr_q;
        valid_d      = valid_q;
        fence_pend_d = (fence_pend_q | fence_i) & ~fence_apply;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        err_d        = err_q;
        m_arvalid_d  = m_arvalid_q;
        cnt_d        = cnt_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        data_waddr   = {idx, cnt_q[OFFW-1:0]};

        if (fence_apply) begin
            valid_d = '0;
        end
        if (s_arvalid && s_arready) begin
            addr_d = s_araddr;
        end

        unique case (state_q)
            LOOKUP: begin
                rresp_d = 2'b00;
                if (hit) begin
                    rdata_d = data_q[{idx, off}];
                end else begin
                    m_arvalid_d = 1'b1;
                    err_d       = 1'b0;
                end
            end
            MISS_AR: begin
                if (m_arready) begin
                    m_arvalid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            REFILL: begin
                if (beat) begin
                    if (!cnt_ovf) begin
                        data_we = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q[OFFW-1:0] == off) begin
                            rdata_d = m_rdata;
                        end
                    end
                    // First nonzero code is reported; later codes only keep the line invalid
                    if (rresp_q == 2'b00) begin
                        rresp_d = beat_code;
                    end
                    err_d = err_q | (beat_code != 2'b00);
                    if (m_rlast) begin
                        tag_we       = 1'b1;
                        valid_d[idx] = !(err_q || (beat_code != 2'b00));
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q       <= '0;
            valid_q      <= '0;
            fence_pend_q <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= 2'b00;
            err_q        <= 1'b0;
            m_arvalid_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            fence_pend_q <= fence_pend_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            err_q        <= err_d;
            m_arvalid_q  <= m_arvalid_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (data_we) begin
            data_q[data_waddr] <= m_rdata;
        end
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
    end

    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = 1'b1;
    assign s_rid     = '0;
    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = {addr_q[31:LSB], {LSB{1'b0}}};
    assign m_arid    = '0;
    assign m_arlen   = 8'(WORDS - 1);
    assign m_arsize  = 3'd2;
    assign m_arburst = 2'b01;

    assign unused_inputs = ^{s_arid, s_arlen, s_arsize, s_arburst, addr_q[1:0]};

endmodule

// File: tb/tb_ysyx_24080006_icache.sv
// Bench for ysyx_24080006_icache: directed vector table, multi-cycle corner sequences and
// randomized fetches against a direct-mapped cache model plus a burst memory slave.
module tb_ysyx_24080006_icache;
    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        fence_i, fence_main, fence_slave;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;

    assign fence_i = fence_main | fence_slave;

    always #5 clock = ~clock;

    ysyx_24080006_icache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clock(clock), .reset(reset), .fence_i(fence_i),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:2], 2'b01, ~a[15:0]} ^ 32'h5A3C_0F00;
    endfunction

    // Memory slave knobs and observations
    int          ar_delay        = 0;
    int          err_beat        = -1;
    logic [1:0]  err_code        = 2'b00;
    int          last_beats      = WORDS;
    bit          fence_in_refill = 1'b0;
    bit          rand_gaps       = 1'b0;
    int          bursts          = 0;
    int          addr_unstable   = 0;
    logic [31:0] last_araddr;
    logic [7:0]  last_arlen;
    logic [2:0]  last_arsize;
    logic [1:0]  last_arburst;

    initial begin
        logic [31:0] sa;
        bit          hs;
        int          hg;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
        fence_slave = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset && m_arvalid) begin
                sa = m_araddr;
                last_araddr = m_araddr; last_arlen = m_arlen;
                last_arsize = m_arsize; last_arburst = m_arburst;
                for (int d = 0; d < ar_delay; d++) begin
                    @(posedge clock); #1;
                    if (m_araddr !== sa || m_arvalid !== 1'b1) addr_unstable++;
                end
                m_arready = 1'b1;
                @(posedge clock); #1;
                m_arready = 1'b0;
                bursts++;
                for (int b = 0; b < last_beats; b++) begin
                    if (rand_gaps && $urandom_range(0, 2) == 0) begin
                        @(posedge clock); #1;
                    end
                    m_rvalid    = 1'b1;
                    m_rdata     = mem_word(sa + 32'(4 * b));
                    m_rresp     = (b == err_beat) ? err_code : 2'b00;
                    m_rlast     = (b == last_beats - 1);
                    fence_slave = fence_in_refill && (b == 1);
                    hg = 0;
                    do begin
                        hs = m_rready;
                        @(posedge clock); #1;
                        hg++;
                    end while (!hs && hg < 50);
                    fence_slave = 1'b0;
                    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
                end
            end
        end
    end

    // One IFU read: request, wait for response, hold rready low for `hold` cycles, accept
    task automatic fetch(input logic [31:0] a, input int hold, output logic [31:0] d,
                         output logic [1:0] r, output int lat, output bit stable);
        int g;
        s_arvalid = 1'b1;
        s_araddr  = a;
        g = 0;
        while (!s_arready && g < 200) begin @(posedge clock); #1; g++; end
        if (g >= 200) timeout("arready_wait");
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 200) begin @(posedge clock); #1; lat++; end
        if (lat >= 200) timeout("rvalid_wait");
        d = s_rdata;
        r = s_rresp;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            if (s_rvalid !== 1'b1 || s_rdata !== d || s_rresp !== r) stable = 1'b0;
        end
        s_rready = 1'b1;
        @(posedge clock); #1;
        s_rready = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a, input int hold,
                            input bit exp_miss, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          b0;
        bit          stable;
        b0 = bursts;
        fetch(a, hold, d, r, lat, stable);
        check({tag, "_rresp"}, 32'(r), 32'(exp_resp));
        if (exp_resp == 2'b00) check({tag, "_rdata"}, d, mem_word(a));
        check({tag, "_bursts"}, 32'(bursts - b0), 32'(exp_miss));
        if (exp_miss) begin
            check({tag, "_m_araddr"}, last_araddr, a & 32'hFFFF_FFF0);
            check({tag, "_m_arlen"}, 32'(last_arlen), 32'(WORDS - 1));
            check({tag, "_m_arsize_burst"}, {27'd0, last_arsize, last_arburst}, {27'd0, 3'd2, 2'b01});
        end else begin
            check({tag, "_hit_latency"}, 32'(lat), 32'd2);
        end
        check({tag, "_resp_stable"}, 32'(stable), 32'd1);
    endtask

    task automatic pulse_fence();
        fence_main = 1'b1;
        @(posedge clock); #1;
        fence_main = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          fence;
        int          eb;
        logic [1:0]  ecode;
        int          beats;
        int          ard;
        int          hold;
        bit          exp_miss;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [15];

    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];

    initial begin : main
        logic [31:0] a;
        int          li;
        logic [31:0] lt;
        bit          miss, fen, inj;
        logic [1:0]  code, er;

        //              addr           fence eb  code   beats ard hold miss resp
        vecs[0]  = '{32'h3000_0000, 1'b0, -1, 2'd0, 4, 0, 1, 1'b1, 2'd0};
        vecs[1]  = '{32'h3000_0004, 1'b0, -1, 2'd0, 4, 0, 1, 1'b0, 2'd0};
        vecs[2]  = '{32'h3000_0008, 1'b0, -1, 2'd0, 4, 0, 3, 1'b0, 2'd0};
        vecs[3]  = '{32'h3000_000C, 1'b1, -1, 2'd0, 4, 0, 1, 1'b1, 2'd0};
        vecs[4]  = '{32'h3000_0000, 1'b0, -1, 2'd0, 4, 0, 1, 1'b0, 2'd0};
        vecs[5]  = '{32'h3000_0100, 1'b0, -1, 2'd0, 4, 5, 1, 1'b1, 2'd0};
        vecs[6]  = '{32'h3000_0000, 1'b0, -1, 2'd0, 4, 0, 1, 1'b1, 2'd0};
        vecs[7]  = '{32'h3000_0020, 1'b0,  1, 2'd2, 4, 0, 1, 1'b1, 2'd2};
        vecs[8]  = '{32'h3000_0020, 1'b0, -1, 2'd0, 4, 0, 1, 1'b1, 2'd0};
        vecs[9]  = '{32'h3000_0024, 1'b0, -1, 2'd0, 4, 0, 2, 1'b0, 2'd0};
        vecs[10] = '{32'h3000_0048, 1'b0,  3, 2'd3, 4, 2, 1, 1'b1, 2'd3};
        vecs[11] = '{32'h3000_0048, 1'b0, -1, 2'd0, 4, 0, 1, 1'b1, 2'd0};
        vecs[12] = '{32'h3000_0050, 1'b0, -1, 2'd0, 2, 0, 1, 1'b1, 2'd2};
        vecs[13] = '{32'h3000_0050, 1'b0, -1, 2'd0, 4, 0, 1, 1'b1, 2'd0};
        vecs[14] = '{32'h3000_0054, 1'b0, -1, 2'd0, 4, 0, 3, 1'b0, 2'd0};

        reset = 1'b1; fence_main = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = 3'd2;
        s_arburst = 2'b01; s_rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_s_arready", 32'(s_arready), 32'd0);
        check("rst_s_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_s_rdata", s_rdata, 32'd0);
        check("rst_s_rresp", 32'(s_rresp), 32'd0);
        check("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        check("rst_m_rready", 32'(m_rready), 32'd0);
        check("const_ids_last", {26'd0, s_rlast, s_rid, m_arid[0]}, {26'd0, 1'b1, 4'd0, 1'b0});
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_s_arready", 32'(s_arready), 32'd1);

        // Directed vector table
        foreach (vecs[i]) begin
            err_beat = vecs[i].eb; err_code = vecs[i].ecode;
            last_beats = vecs[i].beats; ar_delay = vecs[i].ard;
            if (vecs[i].fence) pulse_fence();
            do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hold, vecs[i].exp_miss, vecs[i].exp_resp);
            err_beat = -1; err_code = 2'b00; last_beats = WORDS; ar_delay = 0;
        end
        check("m_araddr_stable_during_delay", 32'(addr_unstable), 32'd0);

        // Fence pulse repeated in its own application cycle: one blocked cycle only
        fence_main = 1'b1;
        check("fence_cycle0_arready", 32'(s_arready), 32'd1);
        @(posedge clock); #1;
        check("fence_apply_arready", 32'(s_arready), 32'd0);
        @(posedge clock); #1;
        fence_main = 1'b0;
        check("fence_single_clear", 32'(s_arready), 32'd1);
        @(posedge clock); #1;
        check("fence_after_arready", 32'(s_arready), 32'd1);
        do_fetch("after_fence", 32'h3000_0054, 1, 1'b1, 2'd0);

        // Fence during refill: response delivered, line not kept
        fence_in_refill = 1'b1;
        do_fetch("fence_refill", 32'h3000_0204, 1, 1'b1, 2'd0);
        fence_in_refill = 1'b0;
        do_fetch("fence_refill_again", 32'h3000_0204, 1, 1'b1, 2'd0);
        do_fetch("refill_warm", 32'h3000_0208, 1, 1'b0, 2'd0);

        // Reset while a hit response is pending
        s_arvalid = 1'b1; s_araddr = 32'h3000_0200;
        for (int g = 0; g < 20 && !s_arready; g++) begin @(posedge clock); #1; end
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        for (int g = 0; g < 20 && !s_rvalid; g++) begin @(posedge clock); #1; end
        check("pre_reset_rvalid", 32'(s_rvalid), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_rvalid", 32'(s_rvalid), 32'd0);
        check("midrst_rdata", s_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        do_fetch("post_reset", 32'h3000_0200, 1, 1'b1, 2'd0);

        // Randomized fetches against the cache model (model state after the fetch above)
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        mvalid[0] = 1'b1; mtag[0] = 32'h3000_0200 / (16 * LINES);
        rand_gaps = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a = 32'h3000_0000 + 32'($urandom_range(0, 2) * 256 + $urandom_range(0, 3) * 16
                                   + $urandom_range(0, 3) * 4);
            li = int'((a / 16) % LINES);
            lt = a / (16 * LINES);
            fen = ($urandom_range(0, 9) == 0);
            inj = ($urandom_range(0, 7) == 0);
            code = 2'($urandom_range(1, 3));
            ar_delay = int'($urandom_range(0, 3));
            err_beat = inj ? int'($urandom_range(0, WORDS - 1)) : -1;
            err_code = code;
            if (fen) begin
                pulse_fence();
                foreach (mvalid[i]) mvalid[i] = 1'b0;
            end
            miss = !(mvalid[li] && mtag[li] == lt);
            er = (miss && inj) ? code : 2'b00;
            if (miss) begin
                mvalid[li] = !inj;
                mtag[li]   = lt;
            end
            do_fetch($sformatf("rnd%0d", n), a, int'($urandom_range(1, 3)), miss, er);
        end
        err_beat = -1; ar_delay = 0; rand_gaps = 1'b0;
        check("m_araddr_stable_random", 32'(addr_unstable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
